// File: rtl/dnn_layer_pkg.sv
// dnn_layer_pkg: FSM states, activation modes, saturation and sigmoid LUT-index helpers
package dnn_layer_pkg;
  typedef enum logic [2:0] {IDLE, RD_A, RD_W, RD_B, ACC_B, ACT, LUT_WB, DONE} state_t;
  typedef enum logic [1:0] {ACT_ID = 2'b00, ACT_RELU = 2'b01, ACT_SIG = 2'b10} mode_t;
  function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
  function automatic logic [31:0] lut_index(input logic signed [63:0] y, input int shift, input int depth);
    logic signed [63:0] t;
    t = (y >>> shift) + 64'(depth / 2);
    return t[63] ? '0 : t > 64'(depth - 1) ? 32'(depth - 1) : t[31:0];
  endfunction
endpackage

// File: rtl/dnn_layer_ctrl.sv
// dnn_layer_ctrl: layer FSM, i/j counters, memory address generation and datapath strobes
module dnn_layer_ctrl
  import dnn_layer_pkg::*;
#(
  parameter int N_IN = 400,
  parameter int N_OUT = 10,
  parameter int ADDR_WIDTH = 17,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 17'h00000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 17'h00191,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT = 17'h029BE,
  parameter int JW = 4,
  parameter int LW = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic reset,
  input  logic [1:0] mode,
  input  logic [LW-1:0] lut_idx,
  output logic done,
  output logic busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output mode_t act_mode,
  output logic acc_clr,
  output logic acc_mul,
  output logic acc_bias,
  output logic a_load,
  output logic out_we,
  output logic out_clr,
  output logic [JW-1:0] out_sel
);
  localparam int IW = $clog2(N_IN + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW = ADDR_WIDTH'(N_IN + 1);
  state_t state;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic idle;
  logic [ADDR_WIDTH-1:0] row_base;
  always_comb begin
    idle = state == IDLE || state == DONE;
    row_base = ADDR_BASE_W + ADDR_WIDTH'(j) * ROW;
    mem_addr = state == RD_A ? ADDR_BASE_A + ADDR_WIDTH'(i) :
               state == RD_W ? row_base + ADDR_WIDTH'(i) :
               state == RD_B ? row_base + ADDR_WIDTH'(N_IN) :
               state == ACT && act_mode == ACT_SIG ? ADDR_BASE_LUT + ADDR_WIDTH'(lut_idx) : ADDR_BASE_A;
    acc_mul = (state == RD_A && i != '0) || state == RD_B;
    acc_bias = state == ACC_B;
    a_load = state == RD_W;
    acc_clr = reset || (idle && start) || state == ACT;
    out_we = (state == ACT && act_mode != ACT_SIG) || state == LUT_WB;
    out_clr = reset;
    out_sel = j;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      act_mode <= ACT_ID;
    end else if (reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      act_mode <= ACT_ID;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            act_mode <= mode == 2'b01 ? ACT_RELU : mode == 2'b10 ? ACT_SIG : ACT_ID;
            i <= '0;
            j <= '0;
            done <= 1'b0;
            busy <= 1'b1;
            state <= RD_A;
          end
        RD_A: state <= RD_W;
        RD_W:
          if (i < I_LAST) begin
            i <= i + 1'b1;
            state <= RD_A;
          end else state <= RD_B;
        RD_B: state <= ACC_B;
        ACC_B: state <= ACT;
        default: begin
          i <= '0;
          if (state == ACT && act_mode == ACT_SIG) state <= LUT_WB;
          else if (j == J_LAST) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            j <= j + 1'b1;
            state <= RD_A;
          end
        end
      endcase
endmodule

// File: rtl/dnn_layer_datapath.sv
// dnn_layer_datapath: a_reg, MAC accumulator, saturation/activation, LUT index and neuron output registers
module dnn_layer_datapath
  import dnn_layer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int N_IN = 400,
  parameter int N_OUT = 10,
  parameter int LUT_DEPTH = 1024,
  parameter int LUT_SHIFT = 2,
  parameter int JW = 4,
  parameter int LW = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  input  mode_t act_mode,
  input  logic acc_clr,
  input  logic acc_mul,
  input  logic acc_bias,
  input  logic a_load,
  input  logic out_we,
  input  logic out_clr,
  input  logic [JW-1:0] out_sel,
  output logic [LW-1:0] lut_idx,
  output logic [N_OUT*DATA_WIDTH-1:0] out
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + $clog2(N_IN + 1);
  logic signed [DATA_WIDTH-1:0] a_reg;
  logic signed [DATA_WIDTH-1:0] y;
  logic signed [DATA_WIDTH-1:0] wr_val;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [63:0] y64;
  always_comb begin
    prod = PW'(a_reg) * PW'(mem_data);
    addend = acc_mul ? ACC_W'(prod) : acc_bias ? ACC_W'(mem_data) <<< FRAC_BITS : '0;
    y64 = sat_val(64'(acc >>> FRAC_BITS), DATA_WIDTH);
    y = y64[DATA_WIDTH-1:0];
    lut_idx = LW'(lut_index(y64, LUT_SHIFT, LUT_DEPTH));
    wr_val = act_mode == ACT_SIG ? mem_data : act_mode == ACT_RELU && y[DATA_WIDTH-1] ? '0 : y;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_reg <= '0;
      acc <= '0;
      out <= '0;
    end else begin
      if (a_load) a_reg <= mem_data;
      acc <= acc_clr ? '0 : acc + addend;
      if (out_clr) out <= '0;
      else if (out_we)
        for (int k = 0; k < N_OUT; k++)
          if (out_sel == JW'(k)) out[k*DATA_WIDTH +: DATA_WIDTH] <= wr_val;
    end
endmodule

// File: rtl/dnn_dense_layer_engine.sv
// dnn_dense_layer_engine: fixed-point dense layer (MAC over one read port, identity/ReLU/LUT-sigmoid) wiring ctrl to datapath
module dnn_dense_layer_engine
  import dnn_layer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int N_IN = 400,
  parameter int N_OUT = 10,
  parameter int ADDR_WIDTH = 17,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 17'h00000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 17'h00191,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT = 17'h029BE,
  parameter int LUT_DEPTH = 1024,
  parameter int LUT_SHIFT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic reset,
  input  logic [1:0] mode,
  output logic done,
  output logic busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_data,
  output logic [N_OUT*DATA_WIDTH-1:0] out
);
  localparam int JW = $clog2(N_OUT + 1);
  localparam int LW = $clog2(LUT_DEPTH);
  mode_t act_mode;
  logic acc_clr;
  logic acc_mul;
  logic acc_bias;
  logic a_load;
  logic out_we;
  logic out_clr;
  logic [JW-1:0] out_sel;
  logic [LW-1:0] lut_idx;
  dnn_layer_ctrl #(
    .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_WIDTH(ADDR_WIDTH), .ADDR_BASE_A(ADDR_BASE_A),
    .ADDR_BASE_W(ADDR_BASE_W), .ADDR_BASE_LUT(ADDR_BASE_LUT), .JW(JW), .LW(LW)
  ) u_ctrl (
    .clk(clk), .rst(rst), .start(start), .reset(reset), .mode(mode), .lut_idx(lut_idx),
    .done(done), .busy(busy), .mem_addr(mem_addr), .act_mode(act_mode), .acc_clr(acc_clr),
    .acc_mul(acc_mul), .acc_bias(acc_bias), .a_load(a_load), .out_we(out_we),
    .out_clr(out_clr), .out_sel(out_sel)
  );
  dnn_layer_datapath #(
    .DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .N_IN(N_IN), .N_OUT(N_OUT),
    .LUT_DEPTH(LUT_DEPTH), .LUT_SHIFT(LUT_SHIFT), .JW(JW), .LW(LW)
  ) u_dp (
    .clk(clk), .rst(rst), .mem_data(mem_data), .act_mode(act_mode), .acc_clr(acc_clr),
    .acc_mul(acc_mul), .acc_bias(acc_bias), .a_load(a_load), .out_we(out_we),
    .out_clr(out_clr), .out_sel(out_sel), .lut_idx(lut_idx), .out(out)
  );
endmodule

// File: tb/tb_dnn_dense_layer_engine.sv
// tb_dnn_dense_layer_engine: randomized and directed checks of the dense layer against an arithmetic reference model
module tb_dnn_dense_layer_engine;
  localparam int DW = 16;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int AB = 'h0;
  localparam int WB = 'h191;
  localparam int LB = 'h29BE;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic reset;
  logic [1:0] mode;
  logic done;
  logic busy;
  logic [16:0] mem_addr;
  logic signed [DW-1:0] mem_data;
  logic [NO*DW-1:0] out;
  logic [15:0] mem [0:131071];
  logic signed [15:0] av [NI];
  logic signed [15:0] wv [NO][NI];
  logic signed [15:0] bv [NO];
  int n_tests = 0;
  int n_fail = 0;
  int cyc;
  logic [1:0] m;
  int g;

  dnn_dense_layer_engine #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .reset(reset), .mode(mode), .done(done),
    .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data), .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int j, input logic [1:0] md);
    longint s;
    longint y;
    longint idx;
    s = 0;
    for (int i = 0; i < NI; i++) s += longint'(av[i]) * longint'(wv[j][i]);
    s += longint'(bv[j]) * 256;
    y = s >>> 8;
    y = y > 32767 ? 32767 : y < -32768 ? -32768 : y;
    if (md == 2'd1 && y < 0) y = 0;
    if (md != 2'd2) return 16'(y);
    idx = (y >>> 2) + 512;
    idx = idx < 0 ? 0 : idx > 1023 ? 1023 : idx;
    return mem[LB + int'(idx)];
  endfunction

  task automatic load_mem();
    for (int i = 0; i < NI; i++) mem[AB + i] = av[i];
    for (int j = 0; j < NO; j++) begin
      for (int i = 0; i < NI; i++) mem[WB + j * (NI + 1) + i] = wv[j][i];
      mem[WB + j * (NI + 1) + NI] = bv[j];
    end
  endtask

  task automatic run(input logic [1:0] md, input int glitch, output int c);
    @(negedge clk);
    start = 1'b1;
    mode = md;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      start = c == glitch;
      mode = 2'($urandom);
      if (c == 3) begin
        check("busy_mid", busy, 1);
        check("done_mid", done, 0);
      end
    end while (!done && c < 100);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] md);
    for (int j = 0; j < NO; j++) check(tag, out[j*DW +: DW], model(j, md));
  endtask

  task automatic set_all(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < NI; i++) av[i] = a;
    for (int j = 0; j < NO; j++) begin
      for (int i = 0; i < NI; i++) wv[j][i] = w;
      bv[j] = b;
    end
    load_mem();
  endtask

  task automatic set_directed();
    av = '{16'h0100, 16'h0200};
    wv[0] = '{16'h0080, 16'h0040};
    wv[1] = '{16'hFF00, 16'h0000};
    bv = '{16'h0040, 16'h0000};
    load_mem();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[LB + k] = 16'(k * 7 + 3);
    rst = 1'b1;
    start = 1'b0;
    reset = 1'b0;
    mode = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 0);
    check("rst_addr", mem_addr, AB);
    rst = 1'b0;
    @(negedge clk);
    set_directed();
    run(2'd0, 0, cyc);
    check("id_cycles", cyc, 15);
    check("id_out0", out[15:0], 16'h0140);
    check("id_out1", out[31:16], 16'hFF00);
    run(2'd1, 0, cyc);
    check("relu_cycles", cyc, 15);
    check("relu_out0", out[15:0], 16'h0140);
    check("relu_out1", out[31:16], 16'h0000);
    run(2'd2, 0, cyc);
    check("sig_cycles", cyc, 17);
    check("sig_out0", out[15:0], 16'h1033);
    check("sig_out1", out[31:16], 16'h0C43);
    run(2'd0, 5, cyc);
    check("glitch_cycles", cyc, 15);
    check("glitch_out0", out[15:0], 16'h0140);
    set_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run(2'd0, 0, cyc);
    check("sat_pos0", out[15:0], 16'h7FFF);
    check("sat_pos1", out[31:16], 16'h7FFF);
    set_all(16'h7FFF, 16'h8000, 16'h0000);
    run(2'd0, 0, cyc);
    check("sat_neg0", out[15:0], 16'h8000);
    check("sat_neg1", out[31:16], 16'h8000);
    run(2'd2, 0, cyc);
    check("sig_clamp0", out[15:0], 16'h0003);
    set_directed();
    @(negedge clk);
    start = 1'b1;
    mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_out", out, 0);
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", mem_addr, AB);
    @(negedge clk);
    rst = 1'b0;
    run(2'd0, 0, cyc);
    check("post_rst_cycles", cyc, 15);
    check("post_rst_out0", out[15:0], 16'h0140);
    check("post_rst_out1", out[31:16], 16'hFF00);
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("sr_busy", busy, 0);
    check("sr_done", done, 0);
    check("sr_out", out, 0);
    repeat (3) @(negedge clk);
    check("sr_idle", busy, 0);
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NI; i++) av[i] = t[0] ? 16'($urandom) : 16'(int'($urandom_range(0, 2047)) - 1024);
      for (int j = 0; j < NO; j++) begin
        for (int i = 0; i < NI; i++) wv[j][i] = t[0] ? 16'($urandom) : 16'(int'($urandom_range(0, 2047)) - 1024);
        bv[j] = t[0] ? 16'($urandom) : 16'(int'($urandom_range(0, 4095)) - 2048);
      end
      load_mem();
      m = 2'($urandom);
      g = $urandom_range(0, 1) ? $urandom_range(2, 10) : 0;
      run(m, g, cyc);
      check("rnd_cycles", cyc, 1 + NO * (2 * NI + 3 + (m == 2'd2 ? 1 : 0)));
      check_outs("rnd_out", m);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dnn_dense_layer_engine.md
# dnn_dense_layer_engine

Parametrised fixed-point fully-connected layer engine, successor to the fixed-size fp16 sigmoid layer. It computes N_OUT neurons over N_IN activations by multiply-accumulating over a single synchronous read port, then applies a run-time selectable activation: identity, ReLU, or LUT sigmoid. The engine sits between the shared activation/weight/LUT memory and the next layer's input registers, and is chained once per network layer.

## Interface
- DATA_WIDTH, 16, signed data word width
- FRAC_BITS, 8, fractional bits of every data word (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
- N_IN, 400, inputs per neuron
- N_OUT, 10, neurons in the layer
- ADDR_WIDTH, 17, memory address width
- ADDR_BASE_A, 17'h00000, base address of activations a[i]
- ADDR_BASE_W, 17'h00191, base address of weights; w[j][i] is at ADDR_BASE_W + j*(N_IN+1) + i; bias b[j] is at index i = N_IN
- ADDR_BASE_LUT, 17'h029BE, base address of the sigmoid LUT
- LUT_DEPTH, 1024, LUT entries (power of 2)
- LUT_SHIFT, 2, right shift applied to the pre-activation value to form the LUT index

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-high reset
- start, input, 1, one-cycle pulse that launches a layer evaluation; sampled only in IDLE or DONE
- reset, input, 1, synchronous soft clear; returns to IDLE
- mode, input, 2, activation select sampled at start: 00 identity, 01 ReLU, 10 sigmoid, 11 treated as identity
- done, output, 1, level; high in DONE
- busy, output, 1, high in every state except IDLE and DONE
- mem_addr, output, ADDR_WIDTH, combinational read address
- mem_data, input, signed DATA_WIDTH, read data, valid one cycle after mem_addr
- out, output, signed DATA_WIDTH x N_OUT, neuron results

## Operation
- States: IDLE, RD_A, RD_W, RD_B, ACC_B, ACT, LUT_WB, DONE. Counters: i (0..N_IN-1) and j (0..N_OUT-1).
- IDLE/DONE: mem_addr = ADDR_BASE_A. On start: latch mode, clear acc, i and j, deassert done, go to RD_A.
- RD_A: mem_addr = A+i. If i>0, acc += a_reg*mem_data, which is the weight of term i-1.
- RD_W: mem_addr = W(j,i); a_reg <= mem_data. If i<N_IN-1, increment i and go to RD_A; otherwise go to RD_B.
- RD_B: mem_addr = W(j,N_IN); acc += a_reg*mem_data, the last term.
- ACC_B: acc += sign_ext(mem_data) <<< FRAC_BITS.
- ACT: y = sat(acc >>> FRAC_BITS) to DATA_WIDTH.
  - Identity: out[j] <= y.
  - ReLU: out[j] <= (y<0 ? 0 : y).
  - Sigmoid: mem_addr = ADDR_BASE_LUT + idx, where idx = clamp((y >>> LUT_SHIFT) + LUT_DEPTH/2, 0, LUT_DEPTH-1); go to LUT_WB.
  - ACT clears acc and i.
- LUT_WB: out[j] <= mem_data.
- After the write (in ACT or LUT_WB): if j == N_OUT-1 go to DONE, otherwise increment j and go to RD_A.
- Width rules:
  - Product width is 2*DATA_WIDTH with 2*FRAC_BITS fractional bits.
  - acc width is 2*DATA_WIDTH + clog2(N_IN+1) and never wraps.
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Boundaries:
  - start while busy is ignored.
  - start in DONE re-launches; out keeps its old values until each is overwritten.
  - reset has priority over start in the same cycle: go to IDLE, out all zero, done=0.
  - mode changes while busy have no effect.

## Timing
- Reset values (rst, or reset at the next edge): state IDLE, done 0, busy 0, out all 0, acc 0, mem_addr = ADDR_BASE_A.
- Per neuron: 2*N_IN+3 cycles, plus 1 in sigmoid mode.
- Counting the start edge as cycle 0, done rises at cycle 1 + N_OUT*(2*N_IN+3+s), where s=1 for sigmoid and 0 otherwise.
- out[j] updates on the final edge of neuron j.
- Async rst mid-run aborts immediately; no partial-result guarantee beyond all zeros.

## Structure
- Package dnn_layer_pkg:
  - state enum
  - mode enum (ACT_ID, ACT_RELU, ACT_SIG)
  - saturate and LUT-index functions, parametrised by width
- Sub-modules:
  - dnn_layer_datapath: a_reg, multiplier, acc, saturation, LUT index, out registers.
  - dnn_layer_ctrl: FSM, counters, address generation.
- The top-level dnn_dense_layer_engine only wires the two together.

## Test plan
Configuration: N_IN=2, N_OUT=2, Q8.8, single-cycle-latency memory model.

- **Identity.** a=[0x0100,0x0200], w0=[0x0080,0x0040], b0=0x0040; mode 00 -> out[0]=0x0140; done at cycle 15.
- **ReLU.** w1=[0xFF00,0x0000], b1=0; mode 01 -> out[1]=0x0000. With mode 00 the same input gives out[1]=0xFF00.
- **Sigmoid.** Pre-activation 0x0140 -> LUT read at ADDR_BASE_LUT+592; out[0] equals the LUT word. Done at cycle 17.
- **Saturation and clamp.**
  - a=w=0x7FFF, b=0x7FFF -> out=0x7FFF.
  - a=0x7FFF, w=0x8000 -> out=0x8000; in sigmoid mode the LUT index is 0.
- **Reset mid-run.**
  - Async rst asserted during the RD_W of neuron 1 -> out all 0, done=0, busy=0 immediately.
  - A subsequent start completes normally.
- **Control corner cases.**
  - start pulsed while busy -> ignored; done timing unchanged.
  - start and reset in the same cycle -> stays IDLE.
